// File: rtl/cpu_ctrl_seq.sv
// -----------------------------------------------------------------------------
// cpu_ctrl_seq
// Control sequencer for the simple CPU. A fetch/decode/execute state machine
// that strobes the register bank (PC, MAR, MDR, IR, ACC), issues memory
// read/write requests with a ready handshake, selects the bus source and
// picks the ALU operation.
//
// Ports
//   clk        in   1    clock, all state changes on rising edge
//   rst        in   1    synchronous reset, active-low (0 = reset)
//   ir         in   IW   current instruction register contents
//   acc_zero   in   1    ACC == 0 flag
//   mem_ready  in   1    memory completes current rd/wr this cycle
//   pc_load    out  1    PC <= bus
//   pc_inc     out  1    PC <= PC + 1
//   mar_load   out  1    MAR <= bus
//   mdr_load   out  1    MDR <= bus (bus_sel=ACC) or memory data (mem_rd)
//   ir_load    out  1    IR <= MDR
//   acc_load   out  1    ACC <= ALU result
//   mem_rd     out  1    memory read request, held until mem_ready
//   mem_wr     out  1    memory write request, held until mem_ready
//   bus_sel    out  2    bus source: 0 PC, 1 IR address field, 2 ACC, 3 MDR
//   alu_op     out  2    0 pass, 1 add, 2 sub
//   halted     out  1    FSM in HALT
//
// Strobes are decoded from the current state. The only input-dependent terms
// are the completion strobes in the memory wait states (they must line up with
// the cycle the memory reports ready) and the reset gate, which forces every
// output low in the cycle reset is applied so a pending request drops at once.
// -----------------------------------------------------------------------------
module cpu_ctrl_seq #(
    parameter int OPW = 4,
    parameter int IW  = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [IW-1:0] ir,
    input  logic          acc_zero,
    input  logic          mem_ready,
    output logic          pc_load,
    output logic          pc_inc,
    output logic          mar_load,
    output logic          mdr_load,
    output logic          ir_load,
    output logic          acc_load,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [1:0]    bus_sel,
    output logic [1:0]    alu_op,
    output logic          halted
);

    localparam logic [OPW-1:0] OP_NOP = OPW'(4'h0);
    localparam logic [OPW-1:0] OP_LDA = OPW'(4'h1);
    localparam logic [OPW-1:0] OP_STA = OPW'(4'h2);
    localparam logic [OPW-1:0] OP_ADD = OPW'(4'h3);
    localparam logic [OPW-1:0] OP_SUB = OPW'(4'h4);
    localparam logic [OPW-1:0] OP_JMP = OPW'(4'h5);
    localparam logic [OPW-1:0] OP_JZ  = OPW'(4'h6);
    localparam logic [OPW-1:0] OP_HLT = OPW'(4'hF);

    localparam logic [1:0] BUS_PC  = 2'd0;
    localparam logic [1:0] BUS_IRA = 2'd1;
    localparam logic [1:0] BUS_ACC = 2'd2;
    localparam logic [1:0] BUS_MDR = 2'd3;

    localparam logic [1:0] ALU_PASS = 2'd0;
    localparam logic [1:0] ALU_ADD  = 2'd1;
    localparam logic [1:0] ALU_SUB  = 2'd2;

    typedef enum logic [3:0] {
        S_FETCH_A = 4'd0,
        S_FETCH_B = 4'd1,
        S_FETCH_C = 4'd2,
        S_DECODE  = 4'd3,
        S_EX_ADDR = 4'd4,
        S_EX_MEM  = 4'd5,
        S_EX_ALU  = 4'd6,
        S_ST_DATA = 4'd7,
        S_ST_WR   = 4'd8,
        S_JUMP    = 4'd9,
        S_HALT    = 4'd10
    } state_t;

    state_t         state_r;
    state_t         next_state_s;
    logic [OPW-1:0] opcode_s;

    assign opcode_s = ir[IW-1 -: OPW];

    // Opcodes that read an operand from memory and write ACC.
    function automatic logic is_alu_load(input logic [OPW-1:0] op);
        return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB);
    endfunction

    // ALU operation for the operand-reading opcodes; anything else passes.
    function automatic logic [1:0] alu_for(input logic [OPW-1:0] op);
        logic [1:0] res;
        case (op)
            OP_ADD:  res = ALU_ADD;
            OP_SUB:  res = ALU_SUB;
            default: res = ALU_PASS;
        endcase
        return res;
    endfunction

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= S_FETCH_A;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state and strobe decode.
    always_comb begin
        next_state_s = state_r;
        pc_load      = 1'b0;
        pc_inc       = 1'b0;
        mar_load     = 1'b0;
        mdr_load     = 1'b0;
        ir_load      = 1'b0;
        acc_load     = 1'b0;
        mem_rd       = 1'b0;
        mem_wr       = 1'b0;
        bus_sel      = BUS_PC;
        alu_op       = ALU_PASS;
        halted       = 1'b0;

        if (!rst) begin
            next_state_s = S_FETCH_A;
        end else begin
            case (state_r)
                S_FETCH_A: begin
                    mar_load     = 1'b1;
                    bus_sel      = BUS_PC;
                    next_state_s = S_FETCH_B;
                end
                S_FETCH_B: begin
                    mem_rd  = 1'b1;
                    bus_sel = BUS_PC;
                    if (mem_ready) begin
                        mdr_load     = 1'b1;
                        pc_inc       = 1'b1;
                        next_state_s = S_FETCH_C;
                    end else begin
                        next_state_s = S_FETCH_B;
                    end
                end
                S_FETCH_C: begin
                    ir_load      = 1'b1;
                    next_state_s = S_DECODE;
                end
                S_DECODE: begin
                    if (is_alu_load(opcode_s) || (opcode_s == OP_STA)) begin
                        next_state_s = S_EX_ADDR;
                    end else if (opcode_s == OP_JMP) begin
                        next_state_s = S_JUMP;
                    end else if (opcode_s == OP_JZ) begin
                        next_state_s = acc_zero ? S_JUMP : S_FETCH_A;
                    end else if (opcode_s == OP_HLT) begin
                        next_state_s = S_HALT;
                    end else begin
                        // NOP and every unassigned opcode fall through here.
                        next_state_s = S_FETCH_A;
                    end
                end
                S_EX_ADDR: begin
                    mar_load = 1'b1;
                    bus_sel  = BUS_IRA;
                    if (opcode_s == OP_STA) begin
                        next_state_s = S_ST_DATA;
                    end else begin
                        next_state_s = S_EX_MEM;
                    end
                end
                S_EX_MEM: begin
                    mem_rd = 1'b1;
                    if (mem_ready) begin
                        mdr_load     = 1'b1;
                        next_state_s = S_EX_ALU;
                    end else begin
                        next_state_s = S_EX_MEM;
                    end
                end
                S_EX_ALU: begin
                    acc_load     = 1'b1;
                    bus_sel      = BUS_MDR;
                    alu_op       = alu_for(opcode_s);
                    next_state_s = S_FETCH_A;
                end
                S_ST_DATA: begin
                    mdr_load     = 1'b1;
                    bus_sel      = BUS_ACC;
                    next_state_s = S_ST_WR;
                end
                S_ST_WR: begin
                    mem_wr = 1'b1;
                    if (mem_ready) begin
                        next_state_s = S_FETCH_A;
                    end else begin
                        next_state_s = S_ST_WR;
                    end
                end
                S_JUMP: begin
                    pc_load      = 1'b1;
                    bus_sel      = BUS_IRA;
                    next_state_s = S_FETCH_A;
                end
                S_HALT: begin
                    halted       = 1'b1;
                    next_state_s = S_HALT;
                end
                default: begin
                    // Unreachable encodings recover to a fresh fetch.
                    next_state_s = S_FETCH_A;
                end
            endcase
        end
    end

endmodule
